fetch_redirect: RTL and testbench
=================================

FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, meaning the first instruction address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  pipeline hold; PC state frozen while high.
REQ-005 SHALL have port branch_e  input  1  taken-branch decision from the execute stage.
REQ-006 SHALL have port branch_target_e  input  32  branch target from the execute stage.
REQ-007 SHALL have port jump_e  input  1  J/JAL/JR/JALR taken in the execute stage.
REQ-008 SHALL have port jump_target_e  input  32  jump target from the execute stage.
REQ-009 SHALL have port imem_addr  output  32  synchronous-read instruction memory address, equal to next PC, combinational.
REQ-010 SHALL have port pc_f  output  32  registered PC of the instruction currently in fetch.
REQ-011 SHALL have port pc_plus4_f  output  32  pc_f + 4, modulo 2^32.
REQ-012 SHALL have port valid_f  output  1  instruction word in fetch is architecturally valid.
REQ-013 SHALL have port redirect_pending  output  1  a redirect is captured but not yet applied.
REQ-014 SHALL have port misalign  output  1  one-cycle pulse: an applied redirect target had bits [1:0] != 0.

Function
REQ-015 SHALL implement states BOOT, RUN, HOLD, HOLD_REDIR.
REQ-016 SHALL compute next PC by priority: BOOT -> RESET_PC; stall -> pc_f (hold); pending redirect -> pending target; jump_e -> jump_target_e; branch_e -> branch_target_e; else pc_f + 4.
REQ-017 SHALL give jump_e priority over branch_e when both are high in the same cycle.
REQ-018 SHALL force bits [1:0] of every applied redirect target to 2'b00, and pulse misalign for the one cycle in which that target is loaded into pc_f.
REQ-019 SHALL honour the MIPS delay slot: the instruction fetched while branch_e/jump_e is high (the delay slot) SHALL NOT be squashed, and valid_f SHALL stay 1 for it.
REQ-020 SHALL produce a redirect with zero-cycle decision-to-address latency: imem_addr equals the target in the same cycle that branch_e or jump_e is high with stall low, and pc_f equals the target after the next edge.
REQ-021 SHALL, when branch_e or jump_e is high while stall is high, capture the selected target into a pending register, set redirect_pending, and go to HOLD_REDIR.
REQ-022 SHALL ignore branch_e and jump_e while in HOLD_REDIR, so the first captured target wins.
REQ-023 SHALL, on the first edge with stall low in HOLD_REDIR, load pc_f with the pending target, clear redirect_pending, and go to RUN.
REQ-024 SHALL transition RUN -> HOLD on stall with no redirect, HOLD -> RUN on stall low, and BOOT -> RUN on the first edge with stall low.
REQ-025 SHALL hold pc_f, valid_f and the state unchanged on every edge where stall is high, except for the capture in REQ-021.
REQ-026 SHALL wrap pc_f + 4 from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-027 SHALL, while rst_n is low, force state to BOOT, pc_f to RESET_PC, valid_f to 0, redirect_pending to 0, misalign to 0, and the pending target to 0, independent of clk.
REQ-028 SHALL drive imem_addr = RESET_PC while in reset and in BOOT.
REQ-029 SHALL discard any captured redirect when reset asserts mid-operation; the first fetch after release is RESET_PC.

Verification
REQ-030 Reset release with stall=0: imem_addr=4000_0000 during BOOT; after 1st edge pc_f=4000_0000, valid_f=1; after 2nd edge pc_f=4000_0004.
REQ-031 With pc_f=4000_0010 and branch_e=1, target=4000_0100: imem_addr=4000_0100 in the same cycle; next pc_f=4000_0100; the delay slot at 4000_0010 remains valid.
REQ-032 With jump_e=1 (target 4000_0200) and branch_e=1 (target 4000_0300) together: next pc_f=4000_0200.
REQ-033 branch_e=1 (target 4000_0080) with stall=1 for 3 cycles, then a later jump_e with stall still high: redirect_pending=1 throughout, pc_f frozen; when stall drops, pc_f=4000_0080.
REQ-034 jump_target_e=4000_0103: pc_f=4000_0100 and misalign pulses for exactly 1 cycle.
REQ-035 pc_f=FFFF_FFFC, no redirect -> next pc_f=0000_0000; rst_n low in HOLD_REDIR -> redirect_pending=0 immediately; after release pc_f=4000_0000.

Source files
------------

// File: rtl/fetch_redirect.sv
// -----------------------------------------------------------------------------
// fetch_redirect
//
// Fetch-stage program counter with MIPS-style delayed redirect handling.
//
// The block owns pc_f (the PC of the word currently in fetch) and drives the
// address of a synchronous-read instruction memory. imem_addr is the *next*
// PC and is combinational, so a taken branch or jump decided in execute
// reaches the memory in the same cycle (zero-cycle decision-to-address
// latency). The word already in fetch when the decision arrives is the delay
// slot and is never squashed.
//
// If the decision arrives while the pipeline is stalled, the target is parked
// in a pending register and applied on the first unstalled edge. Later
// decisions during that wait are ignored, so the first captured target wins.
//
// Ports
//   clk              in   single clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   stall            in   pipeline hold; PC state frozen while high
//   branch_e         in   taken-branch decision from execute
//   branch_target_e  in   [31:0] branch target from execute
//   jump_e           in   J/JAL/JR/JALR taken in execute (beats branch_e)
//   jump_target_e    in   [31:0] jump target from execute
//   imem_addr        out  [31:0] next PC, combinational, to the imem
//   pc_f             out  [31:0] registered PC of the word in fetch
//   pc_plus4_f       out  [31:0] pc_f + 4, wrapping at 2^32
//   valid_f          out  word in fetch is architecturally valid
//   redirect_pending out  a redirect is parked and not yet applied
//   misalign         out  one-cycle pulse: applied target had bits [1:0] != 0
// -----------------------------------------------------------------------------
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_e,
  input  logic [31:0] branch_target_e,
  input  logic        jump_e,
  input  logic [31:0] jump_target_e,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        valid_f,
  output logic        redirect_pending,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD       = 2'd2,
    HOLD_REDIR = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic        mis_q, mis_d;

  logic        redir_req;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;

  // Instruction fetch is word-granular; the low two bits of any redirect
  // target are dropped when it becomes a PC.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Jump wins over branch when execute raises both in the same cycle.
  always_comb begin
    redir_req = jump_e | branch_e;
    redir_tgt = jump_e ? jump_target_e : branch_target_e;
  end

  // Next-PC selection, highest priority first. BOOT also covers the time
  // spent in reset, so imem_addr reads RESET_PC throughout reset.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (state_q == BOOT) begin
      next_pc = RESET_PC;
    end else if (stall) begin
      next_pc = pc_q;
    end else if (state_q == HOLD_REDIR) begin
      next_pc = word_align(pend_tgt_q);
    end else if (redir_req) begin
      next_pc = word_align(redir_tgt);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    mis_d      = 1'b0;

    case (state_q)
      BOOT: begin
        if (!stall) begin
          state_d = RUN;
          pc_d    = next_pc;
          valid_d = 1'b1;
        end
      end

      RUN, HOLD: begin
        if (stall) begin
          // A decision that lands during a stall cannot be applied yet;
          // park it so it is not lost when execute moves on.
          if (redir_req) begin
            state_d    = HOLD_REDIR;
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
          end else begin
            state_d = HOLD;
          end
        end else begin
          state_d = RUN;
          pc_d    = next_pc;
          mis_d   = redir_req && is_misaligned(redir_tgt);
        end
      end

      HOLD_REDIR: begin
        // branch_e / jump_e are deliberately not looked at here: the first
        // parked target is the architecturally correct one.
        if (!stall) begin
          state_d    = RUN;
          pc_d       = next_pc;
          pend_d     = 1'b0;
          pend_tgt_d = 32'h0;
          mis_d      = is_misaligned(pend_tgt_q);
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_addr        = next_pc;
  assign pc_f             = pc_q;
  assign pc_plus4_f       = pc_q + 32'd4;
  assign valid_f          = valid_q;
  assign redirect_pending = pend_q;
  assign misalign         = mis_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// -----------------------------------------------------------------------------
// tb_fetch_redirect
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// "has fetch started", the current PC and a queue of parked redirect targets;
// every cycle the bench predicts imem_addr before the edge and the registered
// outputs after it.
// -----------------------------------------------------------------------------
module tb_fetch_redirect;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_e = 1'b0;
  logic [31:0] branch_target_e = 32'h0;
  logic        jump_e = 1'b0;
  logic [31:0] jump_target_e = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        valid_f;
  logic        redirect_pending;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_redirect #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .branch_e         (branch_e),
    .branch_target_e  (branch_target_e),
    .jump_e           (jump_e),
    .jump_target_e    (jump_target_e),
    .imem_addr        (imem_addr),
    .pc_f             (pc_f),
    .pc_plus4_f       (pc_plus4_f),
    .valid_f          (valid_f),
    .redirect_pending (redirect_pending),
    .misalign         (misalign)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_mis;
  logic [31:0] m_pend[$];

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] model_addr();
    if (!m_started)           return RST_PC;
    if (stall)                return m_pc;
    if (m_pend.size() != 0)   return word(m_pend[0]);
    if (jump_e)               return word(jump_target_e);
    if (branch_e)             return word(branch_target_e);
    return m_pc + 32'd4;
  endfunction

  task automatic check_regs();
    chk32("pc_f", pc_f, m_pc);
    chk32("pc_plus4_f", pc_plus4_f, m_pc + 32'd4);
    chk1("valid_f", valid_f, m_valid);
    chk1("redirect_pending", redirect_pending, m_pend.size() != 0);
    chk1("misalign", misalign, m_mis);
  endtask

  // One clock: predict imem_addr, take the edge, advance the model, compare.
  // Entered and left 1 time unit after a rising edge.
  task automatic step();
    logic [31:0] t;
    #1;
    chk32("imem_addr", imem_addr, model_addr());
    @(posedge clk);
    #1;
    m_mis = 1'b0;
    if (!m_started) begin
      if (!stall) begin
        m_started = 1'b1;
        m_pc      = RST_PC;
        m_valid   = 1'b1;
      end
    end else if (stall) begin
      if (m_pend.size() == 0 && (jump_e || branch_e))
        m_pend.push_back(jump_e ? jump_target_e : branch_target_e);
    end else if (m_pend.size() != 0) begin
      t     = m_pend.pop_front();
      m_pc  = word(t);
      m_mis = (t[1:0] != 2'b00);
    end else if (jump_e) begin
      m_pc  = word(jump_target_e);
      m_mis = (jump_target_e[1:0] != 2'b00);
    end else if (branch_e) begin
      m_pc  = word(branch_target_e);
      m_mis = (branch_target_e[1:0] != 2'b00);
    end else begin
      m_pc = m_pc + 32'd4;
    end
    check_regs();
  endtask

  // Assert reset between edges, check the asynchronous effect, hold across
  // two edges, release between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    m_started = 1'b0;
    m_pc      = RST_PC;
    m_valid   = 1'b0;
    m_mis     = 1'b0;
    m_pend.delete();
    #1;
    chk1("rst_async_pending", redirect_pending, 1'b0);
    chk32("rst_imem_addr", imem_addr, RST_PC);
    check_regs();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    chk32("rst_hold_imem_addr", imem_addr, RST_PC);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // Boot sequence with stall low
    stall = 1'b0;
    #1 chk32("boot_addr", imem_addr, 32'h4000_0000);
    step();
    chk32("boot_pc0", pc_f, 32'h4000_0000);
    chk1("boot_valid", valid_f, 1'b1);
    step();
    chk32("boot_pc1", pc_f, 32'h4000_0004);
    repeat (3) step();
    chk32("seq_pc", pc_f, 32'h4000_0010);

    // Taken branch: same-cycle address, delay slot stays valid
    branch_e = 1'b1; branch_target_e = 32'h4000_0100;
    #1 chk32("br_addr_same_cycle", imem_addr, 32'h4000_0100);
    chk1("delay_slot_valid", valid_f, 1'b1);
    step();
    branch_e = 1'b0;
    chk32("br_pc", pc_f, 32'h4000_0100);
    chk1("br_valid", valid_f, 1'b1);

    // Jump beats branch
    jump_e = 1'b1; jump_target_e = 32'h4000_0200;
    branch_e = 1'b1; branch_target_e = 32'h4000_0300;
    step();
    jump_e = 1'b0; branch_e = 1'b0;
    chk32("jump_prio_pc", pc_f, 32'h4000_0200);

    // Redirect during a stall, later decision ignored
    stall = 1'b1; branch_e = 1'b1; branch_target_e = 32'h4000_0080;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("stall_pending", redirect_pending, 1'b1);
      chk32("stall_pc_frozen", pc_f, 32'h4000_0200);
    end
    branch_e = 1'b0; jump_e = 1'b1; jump_target_e = 32'h4000_0500;
    step();
    chk1("stall_jump_ignored_pend", redirect_pending, 1'b1);
    chk32("stall_jump_ignored_pc", pc_f, 32'h4000_0200);
    jump_e = 1'b0; stall = 1'b0;
    #1 chk32("pend_apply_addr", imem_addr, 32'h4000_0080);
    step();
    chk32("pend_apply_pc", pc_f, 32'h4000_0080);
    chk1("pend_cleared", redirect_pending, 1'b0);

    // Misaligned jump target
    jump_e = 1'b1; jump_target_e = 32'h4000_0103;
    step();
    jump_e = 1'b0;
    chk32("mis_pc", pc_f, 32'h4000_0100);
    chk1("mis_pulse", misalign, 1'b1);
    step();
    chk1("mis_pulse_end", misalign, 1'b0);
    chk32("mis_next_pc", pc_f, 32'h4000_0104);

    // Misaligned parked target
    stall = 1'b1; jump_e = 1'b1; jump_target_e = 32'h4000_0042;
    step();
    jump_e = 1'b0;
    step();
    chk1("pend_mis_quiet", misalign, 1'b0);
    stall = 1'b0;
    step();
    chk32("pend_mis_pc", pc_f, 32'h4000_0040);
    chk1("pend_mis_pulse", misalign, 1'b1);

    // Wrap at the top of the address space
    jump_e = 1'b1; jump_target_e = 32'hFFFF_FFFC;
    step();
    jump_e = 1'b0;
    chk32("wrap_pre", pc_f, 32'hFFFF_FFFC);
    chk32("wrap_plus4", pc_plus4_f, 32'h0000_0000);
    step();
    chk32("wrap_pc", pc_f, 32'h0000_0000);

    // Reset while a redirect is parked
    stall = 1'b1; branch_e = 1'b1; branch_target_e = 32'h1234_5678;
    step();
    chk1("hr_pending", redirect_pending, 1'b1);
    do_reset();
    stall = 1'b0; branch_e = 1'b0;
    step();
    chk32("post_reset_pc", pc_f, 32'h4000_0000);

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        stall    = ($urandom_range(2) == 0);
        branch_e = ($urandom_range(3) == 0);
        jump_e   = ($urandom_range(4) == 0);
        branch_target_e = $urandom();
        jump_target_e   = $urandom();
        if ($urandom_range(3) != 0) branch_target_e[1:0] = 2'b00;
        if ($urandom_range(3) != 0) jump_target_e[1:0]   = 2'b00;
        if ($urandom_range(15) == 0) jump_target_e = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
